// File: rtl/bypass_ctrl_pkg.sv
// Shared constants for the forwarding/hazard controller: register index width,
// forward-select stage codes, in-flight entry layout and mult/div latency default.
package bypass_ctrl_pkg;

    localparam int REG_W      = 5;
    localparam int STAGES     = 3;
    localparam int MD_LATENCY = 32;

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_X  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;
    localparam logic [1:0] SEL_W  = 2'd3;

    // One tracked stage: a register write still travelling down the pipe
    typedef struct packed {
        logic             valid;
        logic             we;
        logic             is_load;
        logic [REG_W-1:0] rd;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/bypass_match.sv
// Priority comparator: finds the youngest in-flight writer of one source
// register and returns its stage number, or 0 to read the register file.
module bypass_match #(
    parameter int REG_W  = bypass_ctrl_pkg::REG_W,
    parameter int STAGES = bypass_ctrl_pkg::STAGES,
    parameter int SEL_W  = 2
) (
    input  logic [STAGES-1:0]       wr_valid,
    input  logic [STAGES*REG_W-1:0] wr_rd,
    input  logic [REG_W-1:0]        src,
    output logic [SEL_W-1:0]        sel
);
    import bypass_ctrl_pkg::*;

    // Scan oldest to youngest so the youngest match is the one left standing
    always_comb begin
        sel = SEL_W'(SEL_RF);
        if (src != '0) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (wr_valid[k-1] && (wr_rd[(k-1)*REG_W +: REG_W] == src)) begin
                    sel = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/bypass_ctrl.sv
// Forwarding and hazard controller: tracks in-flight register writes, drives the
// operand forward selects, and raises load-use and mult/div stalls.
module bypass_ctrl #(
    parameter int REG_W      = bypass_ctrl_pkg::REG_W,
    parameter int STAGES     = bypass_ctrl_pkg::STAGES,
    parameter int SEL_W      = 2,
    parameter int MD_LATENCY = bypass_ctrl_pkg::MD_LATENCY
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             dec_valid,
    input  logic             dec_we,
    input  logic             dec_is_load,
    input  logic             dec_is_md,
    input  logic [REG_W-1:0] dec_rd,
    input  logic [REG_W-1:0] dec_rs,
    input  logic [REG_W-1:0] dec_rt,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done
);
    localparam int CNT_W = $clog2(MD_LATENCY + 1);

    logic [STAGES:1]        ent_valid;
    logic [STAGES:1]        ent_we;
    logic [STAGES:1]        ent_load;
    logic [REG_W-1:0]       ent_rd [1:STAGES];

    logic [STAGES-1:0]      wr_valid;
    logic [STAGES*REG_W-1:0] wr_rd;

    logic [CNT_W-1:0]       md_cnt;
    logic [REG_W-1:0]       md_rd;
    logic                   ld_haz;
    logic                   md_haz;
    logic                   md_issue;
    logic                   bubble;

    for (genvar k = 1; k <= STAGES; k++) begin : g_flat
        assign wr_valid[k-1]             = ent_valid[k] & ent_we[k];
        assign wr_rd[(k-1)*REG_W +: REG_W] = ent_rd[k];
    end

    bypass_match #(.REG_W(REG_W), .STAGES(STAGES), .SEL_W(SEL_W)) u_match_a (
        .wr_valid (wr_valid),
        .wr_rd    (wr_rd),
        .src      (dec_rs),
        .sel      (fwd_sel_a)
    );

    bypass_match #(.REG_W(REG_W), .STAGES(STAGES), .SEL_W(SEL_W)) u_match_b (
        .wr_valid (wr_valid),
        .wr_rd    (wr_rd),
        .src      (dec_rt),
        .sel      (fwd_sel_b)
    );

    assign md_busy = (md_cnt != '0);

    // Only a load one stage ahead is too late to forward; older loads forward normally
    assign ld_haz = dec_valid & ent_valid[1] & ent_load[1] & (ent_rd[1] != '0) &
                    ((ent_rd[1] == dec_rs) | (ent_rd[1] == dec_rt));

    assign md_haz = dec_valid & md_busy &
                    (dec_is_md | ((md_rd != '0) &
                     ((dec_rs == md_rd) | (dec_rt == md_rd) | (dec_we & (dec_rd == md_rd)))));

    assign stall    = (ld_haz | md_haz) & ~flush;
    assign bubble   = stall | flush | ~dec_valid;
    assign md_issue = dec_valid & dec_is_md & ~stall & ~flush & ~hold;

    // Hold freezes everything; md_done is a single pulse, so it drops under hold
    always_ff @(posedge clock) begin
        if (reset) begin
            ent_valid <= '0;
            ent_we    <= '0;
            ent_load  <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                ent_rd[k] <= '0;
            end
            md_cnt  <= '0;
            md_rd   <= '0;
            md_done <= 1'b0;
        end else if (hold) begin
            md_done <= 1'b0;
        end else begin
            for (int k = STAGES; k >= 2; k--) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_we[k]    <= ent_we[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_rd[k]    <= ent_rd[k-1];
            end
            ent_valid[1] <= ~bubble;
            ent_we[1]    <= ~bubble & dec_we & ~dec_is_md;
            ent_load[1]  <= ~bubble & dec_is_load;
            ent_rd[1]    <= bubble ? '0 : dec_rd;
            md_done      <= (md_cnt == CNT_W'(1));
            if (md_issue) begin
                md_cnt <= CNT_W'(MD_LATENCY);
                md_rd  <= dec_we ? dec_rd : '0;
            end else if (md_busy) begin
                md_cnt <= md_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bypass_ctrl.sv
// Self-checking bench for bypass_ctrl: directed hazard scenarios followed by
// random traffic, all compared against a queue-based behavioural model.
module tb_bypass_ctrl;

    localparam int REG_W      = 5;
    localparam int STAGES     = 3;
    localparam int SEL_W      = 2;
    localparam int MD_LATENCY = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             hold;
    logic             flush;
    logic             dec_valid;
    logic             dec_we;
    logic             dec_is_load;
    logic             dec_is_md;
    logic [REG_W-1:0] dec_rd;
    logic [REG_W-1:0] dec_rs;
    logic [REG_W-1:0] dec_rt;
    logic [SEL_W-1:0] fwd_sel_a;
    logic [SEL_W-1:0] fwd_sel_b;
    logic             stall;
    logic             md_busy;
    logic             md_done;

    int n_checks = 0;
    int n_errors = 0;

    // Model: queue of writes in flight, index 0 is the youngest (stage 1)
    typedef struct {
        bit valid;
        bit we;
        bit ld;
        int rd;
    } m_ent_t;

    m_ent_t hist[$];
    int     md_left;
    int     md_rd_m;
    bit     done_m;

    always #5 clock = ~clock;

    bypass_ctrl #(
        .REG_W(REG_W), .STAGES(STAGES), .SEL_W(SEL_W), .MD_LATENCY(MD_LATENCY)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hold        (hold),
        .flush       (flush),
        .dec_valid   (dec_valid),
        .dec_we      (dec_we),
        .dec_is_load (dec_is_load),
        .dec_is_md   (dec_is_md),
        .dec_rd      (dec_rd),
        .dec_rs      (dec_rs),
        .dec_rt      (dec_rt),
        .fwd_sel_a   (fwd_sel_a),
        .fwd_sel_b   (fwd_sel_b),
        .stall       (stall),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    function automatic int exp_sel(int src);
        if (src == 0) return 0;
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].valid && hist[i].we && hist[i].rd == src) return i + 1;
        end
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit ld, md;
        int rs, rt, rd;
        rs = int'(dec_rs);
        rt = int'(dec_rt);
        rd = int'(dec_rd);
        ld = dec_valid && hist[0].valid && hist[0].ld && hist[0].rd != 0 &&
             (hist[0].rd == rs || hist[0].rd == rt);
        md = dec_valid && md_left > 0 &&
             (dec_is_md || (md_rd_m != 0 &&
              (rs == md_rd_m || rt == md_rd_m || (dec_we && rd == md_rd_m))));
        return (ld || md) && !flush;
    endfunction

    task automatic model_reset();
        m_ent_t b;
        b = '{0, 0, 0, 0};
        hist.delete();
        for (int i = 0; i < STAGES; i++) hist.push_back(b);
        md_left = 0;
        md_rd_m = 0;
        done_m  = 0;
    endtask

    task automatic model_edge();
        m_ent_t e;
        bit     st;
        st = exp_stall();
        if (reset) begin
            model_reset();
        end else if (hold) begin
            done_m = 0;
        end else begin
            done_m = (md_left == 1);
            if (st || flush || !dec_valid) e = '{0, 0, 0, 0};
            else e = '{1, dec_we && !dec_is_md, dec_is_load, int'(dec_rd)};
            hist.push_front(e);
            void'(hist.pop_back());
            if (dec_valid && dec_is_md && !st && !flush) begin
                md_left = MD_LATENCY;
                md_rd_m = dec_we ? int'(dec_rd) : 0;
            end else if (md_left > 0) begin
                md_left--;
            end
        end
    endtask

    task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(bit v, bit we, bit ld, bit md, int rd, int rs, int rt);
        dec_valid   = v;
        dec_we      = we;
        dec_is_load = ld;
        dec_is_md   = md;
        dec_rd      = REG_W'(rd);
        dec_rs      = REG_W'(rs);
        dec_rt      = REG_W'(rt);
    endtask

    // Compare every output against the model mid-cycle, then advance both
    task automatic step();
        @(negedge clock);
        check_output("fwd_sel_a", fwd_sel_a, exp_sel(int'(dec_rs)));
        check_output("fwd_sel_b", fwd_sel_b, exp_sel(int'(dec_rt)));
        check_output("stall", stall, exp_stall());
        check_output("md_busy", md_busy, md_left > 0);
        check_output("md_done", md_done, done_m);
        model_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        reset = 1'b0;
        #2;
        check_output("reset_sel_a", fwd_sel_a, 0);
        check_output("reset_stall", stall, 0);
        check_output("reset_busy", md_busy, 0);
        check_output("reset_done", md_done, 0);

        // Distance sweep for r5, then r0 which must never forward
        apply_stimulus(1, 1, 0, 0, 5, 0, 0);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 5, 0);
        for (int d = 1; d <= 3; d++) begin
            #2;
            check_output($sformatf("dist_%0d", d), fwd_sel_a, d);
            step();
        end
        #2;
        check_output("dist_gone", fwd_sel_a, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        for (int d = 1; d <= 3; d++) begin
            #2;
            check_output($sformatf("r0_%0d", d), fwd_sel_a, 0);
            step();
        end

        // Two writers of r7: youngest wins; lone old writer forwards from stage 3
        apply_stimulus(1, 1, 0, 0, 7, 0, 0);
        step();
        apply_stimulus(1, 1, 0, 0, 1, 0, 0);
        step();
        apply_stimulus(1, 1, 0, 0, 7, 0, 0);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 7);
        #2;
        check_output("prio_young", fwd_sel_b, 1);
        apply_stimulus(1, 1, 0, 0, 7, 0, 0);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 7);
        #2;
        check_output("prio_old", fwd_sel_b, 3);
        step();

        // Load-use: one stall cycle, then forward from stage 2
        apply_stimulus(1, 1, 1, 0, 9, 0, 0);
        step();
        apply_stimulus(1, 1, 0, 0, 10, 9, 0);
        #2;
        check_output("lu_stall", stall, 1);
        step();
        #2;
        check_output("lu_release", stall, 0);
        check_output("lu_fwd", fwd_sel_a, 2);
        step();

        // Flush overrides a load-use stall and leaves a bubble behind
        apply_stimulus(1, 1, 1, 0, 9, 0, 0);
        step();
        apply_stimulus(1, 1, 0, 0, 10, 9, 0);
        flush = 1'b1;
        #2;
        check_output("flush_stall", stall, 0);
        step();
        flush = 1'b0;
        apply_stimulus(1, 1, 0, 0, 11, 9, 0);
        #2;
        check_output("flush_nostall", stall, 0);
        check_output("flush_fwd", fwd_sel_a, 2);
        step();

        // Hold freezes the tracking pipeline
        apply_stimulus(1, 1, 0, 0, 5, 0, 0);
        step();
        hold = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 5, 0);
        for (int i = 0; i < 4; i++) begin
            #2;
            check_output($sformatf("hold_%0d", i), fwd_sel_a, 1);
            step();
        end
        hold = 1'b0;
        #2;
        check_output("hold_after", fwd_sel_a, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // Divide into r3 with a dependent add waiting the full latency
        apply_stimulus(1, 1, 0, 1, 3, 0, 0);
        step();
        apply_stimulus(1, 1, 0, 0, 4, 3, 0);
        for (int i = 0; i < MD_LATENCY; i++) begin
            #2;
            check_output($sformatf("md_stall_%0d", i), stall, 1);
            check_output($sformatf("md_busy_%0d", i), md_busy, 1);
            check_output($sformatf("md_nodone_%0d", i), md_done, 0);
            step();
        end
        #2;
        check_output("md_done", md_done, 1);
        check_output("md_go", stall, 0);
        check_output("md_fwd", fwd_sel_a, 0);
        step();
        #2;
        check_output("md_done_once", md_done, 0);

        // Reset while a divide and ALU writes are in flight
        apply_stimulus(1, 1, 0, 1, 3, 0, 0);
        step();
        apply_stimulus(1, 1, 0, 0, 5, 0, 0);
        step();
        step();
        #2;
        check_output("rst_pre_busy", md_busy, 1);
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        apply_stimulus(1, 0, 0, 0, 0, 5, 3);
        #2;
        check_output("rst_sel_a", fwd_sel_a, 0);
        check_output("rst_sel_b", fwd_sel_b, 0);
        check_output("rst_stall", stall, 0);
        check_output("rst_busy", md_busy, 0);
        check_output("rst_done", md_done, 0);
        step();
        #2;
        check_output("rst_done_next", md_done, 0);

        // Random traffic over a small register set to provoke collisions
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            hold  = ($urandom_range(0, 99) < 8);
            flush = ($urandom_range(0, 99) < 8);
            dec_valid   = ($urandom_range(0, 99) < 80);
            dec_is_md   = ($urandom_range(0, 99) < 4);
            dec_is_load = !dec_is_md && ($urandom_range(0, 99) < 25);
            dec_we      = ($urandom_range(0, 99) < 85);
            dec_rd      = REG_W'($urandom_range(0, 7));
            dec_rs      = REG_W'($urandom_range(0, 7));
            dec_rt      = REG_W'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bypass_ctrl.md
Name: bypass_ctrl

Overview:
- Parametrised forwarding/hazard controller for the processor pipeline. It generalises single-stage memory bypass detection to STAGES in-flight stages.
- Tracks in-flight register writes in an internal shift pipeline and produces per-operand forward selects for the decode/operand-read point.
- Generates load-use stalls and multicycle mult/div busy stalls.
- Sits beside the pipeline registers and drives the operand muxes and the PC/decode write-enable.

Parameters:
- REG_W, 5, register-index width (32 architectural registers; r0 hardwired zero).
- STAGES, 3, tracked stages after decode (1=X, 2=M, 3=W).
- SEL_W, 2, forward-select width; must satisfy 2^SEL_W > STAGES.
- MD_LATENCY, 32, mult/div cycles from issue to result write (>=2).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- hold  in  1  global freeze (e.g. memory wait); no tracking state changes.
- flush  in  1  branch-mispredict squash of decode and stage 1.
- dec_valid  in  1  decode holds a real instruction.
- dec_we  in  1  decode instruction writes a register.
- dec_is_load  in  1  decode instruction is a load.
- dec_is_md  in  1  decode instruction is mult/div.
- dec_rd  in  REG_W  decode destination.
- dec_rs  in  REG_W  source operand A.
- dec_rt  in  REG_W  source operand B.
- fwd_sel_a  out  SEL_W  0 = regfile, k = forward from stage k.
- fwd_sel_b  out  SEL_W  same for operand B.
- stall  out  1  hold PC/decode, insert bubble into stage 1.
- md_busy  out  1  mult/div in progress.
- md_done  out  1  one-cycle pulse on result write.

Behaviour:
- State: entry[1..STAGES] = {valid, we, is_load, rd}; md counter (width clog2(MD_LATENCY+1)); md_rd register.
- Reset (synchronous, priority over everything): all entries invalid, counter 0, md_rd 0. Outputs stall=0, md_busy=0, md_done=0, fwd_sel_a/b=0.
- Forward select (combinational from current state):
  - fwd_sel_x = smallest k with entry[k].valid & we & rd==src & src!=0; else 0.
  - The youngest writer wins.
  - Forwarding applies even if dec_valid=0; the consumer ignores the result.
- Load-use: ld_haz = dec_valid & entry[1].valid & entry[1].is_load & entry[1].rd!=0 & (rd==dec_rs | rd==dec_rt).
  - Only stage 1 triggers the hazard.
  - A load at stage>=2 is forwarded normally.
- MD hazard: md_haz = dec_valid & md_busy & (dec_is_md | (md_rd!=0 & (dec_rs==md_rd | dec_rt==md_rd | (dec_we & dec_rd==md_rd)))).
- stall = (ld_haz | md_haz) & ~flush. Flush overrides stall, because the stalled instruction is squashed.
- Shift (each edge, priority order):
  - reset.
  - hold: nothing moves, and the md counter also freezes.
  - Otherwise entry[k] <= entry[k-1] for k>=2.
  - entry[1] <= bubble if (stall | flush | ~dec_valid), else {1, dec_we & ~dec_is_md, dec_is_load, dec_rd}.
- MD issue: when dec_valid & dec_is_md & ~stall & ~flush & ~hold, load counter = MD_LATENCY and md_rd = dec_we ? dec_rd : 0.
  - MD ops never enter the forwarding pipeline as writers.
- Counter: decrements when nonzero and ~hold. md_busy = (counter!=0).
  - md_done pulses in the cycle counter transitions 1->0; the regfile is written that cycle.
  - The regfile is write-first, so no stall is needed in the done cycle.
- Flush mid-MD: the in-flight mult/div is not cancelled, because it issued before the branch.
- Back-to-back: an MD issue in the same edge as md_done is allowed. md_haz uses the pre-edge counter, and counter==1 still stalls.
- Width rules:
  - Index comparisons are full REG_W equality.
  - fwd_sel zero-extends k to SEL_W.
  - Counter saturates at 0 and never wraps.

Decomposition:
- Shared package holds:
  - REG_W.
  - Stage-index localparams (SEL_RF=0, SEL_X=1, SEL_M=2, SEL_W=3).
  - The in-flight entry struct/field widths.
  - MD_LATENCY default.
- One natural sub-module: bypass_match. It is a combinational priority comparator over STAGES entries for one source index, instantiated twice (A and B).

Test Plan:
- Distance sweep: ALU write r5 at stage 1, then 2, then 3, with dec_rs=5 -> fwd_sel_a = 1, 2, 3. Repeat with r0 -> always 0.
- Priority: two writers of r7 at stages 1 and 3, dec_rt=7 -> fwd_sel_b=1. With only the stage-3 entry -> 3.
- Load-use: load r9 in stage 1, dec_rs=9 -> stall=1 for exactly one cycle. Next cycle entry[1] is a bubble, the load is at stage 2, stall=0, fwd_sel_a=2.
- Flush vs stall: load-use condition with flush=1 -> stall=0 and entry[1] becomes a bubble next cycle. Hold=1 for 4 cycles -> entries and outputs frozen.
- Mult/div: issue div r3 (MD_LATENCY=32), dependent add reads r3 -> stall for 32 cycles, md_busy=1 throughout, md_done pulses once, and the add issues in the done cycle with fwd_sel_a=0.
- Reset mid-operation: assert reset while md_busy=1 and stage entries are valid -> next edge md_busy=0, all fwd_sel=0, stall=0, and no md_done pulse.
